// File: rtl/ifm_bank_reader.sv
// ifm_bank_reader: streams NUM_BANKS x DEPTH BRAM words, bank by bank, through a 2-entry valid/ready FIFO.
// Optional feature macro READER_CHECKSUM_EN: o_checksum sums the 32-bit lanes of every accepted word.
module ifm_bank_reader #(
    parameter int NUM_BANKS = 16,
    parameter int DEPTH     = 128,
    parameter int DATA_W    = 128,
    parameter int ADDR_W    = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iStart,
    output logic [NUM_BANKS-1:0] o_enb,
    output logic [ADDR_W-1:0]    o_addrb,
    input  logic [DATA_W-1:0]    i_dob,
    output logic [DATA_W-1:0]    o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_last,
    output logic                 o_ready,
    output logic                 o_done,
    output logic [31:0]          o_checksum
);
    localparam int BW = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              r_state, w_next;
    logic                r_start_q;
    logic [BW-1:0]       r_bank;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_inflight, r_inflight_last;
    logic [DATA_W-1:0]   r_mem [2];
    logic [1:0]          r_last_m;
    logic                r_wp, r_rp;
    logic [1:0]          r_cnt;
    logic                w_go, w_pop, w_issue, w_final, w_addr_end;

    assign w_go       = iStart && !r_start_q;
    assign w_addr_end = r_addr == ADDR_W'(DEPTH - 1);
    assign w_final    = w_addr_end && r_bank == BW'(NUM_BANKS - 1);
    assign w_pop      = o_valid && i_ready;
    // A read is only issued if its word is guaranteed a FIFO slot when it lands next cycle.
    assign w_issue    = r_state == RUN && ({1'b0, r_cnt} + {2'b0, r_inflight}) < (3'd2 + {2'b0, w_pop});

    assign o_enb      = w_issue ? NUM_BANKS'(1) << r_bank : '0;
    assign o_addrb    = r_addr;
    assign o_valid    = r_cnt != 2'd0;
    assign o_data     = r_mem[r_rp];
    assign o_last     = o_valid && r_last_m[r_rp];
    assign o_ready    = r_state == IDLE;
    assign o_done     = r_state == DONE;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_next;
    end

    // Next-state: start edge, last read issued, last word accepted, one-cycle done.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_go ? RUN : IDLE;
            RUN:     w_next = (w_issue && w_final) ? DRAIN : RUN;
            DRAIN:   w_next = (w_pop && o_last) ? DONE : DRAIN;
            default: w_next = IDLE;
        endcase
    end

    // Read counters, in-flight tracking and FIFO bookkeeping; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_start_q       <= 1'b0;
            r_bank          <= '0;
            r_addr          <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_last_m        <= '0;
            r_wp            <= 1'b0;
            r_rp            <= 1'b0;
            r_cnt           <= '0;
        end else begin
            r_start_q       <= iStart;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && w_final;
            if (r_state == IDLE && w_go) begin
                r_bank <= '0;
                r_addr <= '0;
            end else if (w_issue) begin
                r_addr <= w_addr_end ? '0 : r_addr + 1'b1;
                r_bank <= w_addr_end ? r_bank + 1'b1 : r_bank;
            end
            if (r_inflight) begin
                r_wp           <= ~r_wp;
                r_last_m[r_wp] <= r_inflight_last;
            end
            if (w_pop) r_rp <= ~r_rp;
            r_cnt <= r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

    // FIFO data storage captures the bank word one cycle after its read.
    always_ff @(posedge clk) begin
        if (r_inflight) r_mem[r_wp] <= i_dob;
    end

`ifdef READER_CHECKSUM_EN
    logic [31:0] r_sum, w_lanes;

    // Lane sum of the word at the FIFO head.
    always_comb begin
        w_lanes = '0;
        for (int i = 0; i < DATA_W / 32; i++) w_lanes = w_lanes + o_data[i*32 +: 32];
    end

    // Accumulate accepted words; cleared when a frame starts, held afterwards.
    always_ff @(posedge clk) begin
        if (rst) r_sum <= '0;
        else if (r_state == IDLE && w_go) r_sum <= '0;
        else if (w_pop) r_sum <= r_sum + w_lanes;
    end

    assign o_checksum = r_sum;
`else
    assign o_checksum = 32'd0;
`endif

endmodule

// File: tb/tb_ifm_bank_reader.sv
// tb_ifm_bank_reader: scoreboard bench for ifm_bank_reader (frame order, stalls, mid-frame reset, restart, checksum).
module tb_ifm_bank_reader;
    localparam int NB = 16, D = 128, DW = 128, AW = 9, NW = NB * D;

    logic          clk = 1'b0, rst = 1'b1, iStart = 1'b0, i_ready = 1'b0;
    logic [NB-1:0] o_enb;
    logic [AW-1:0] o_addrb;
    logic [DW-1:0] i_dob = '0, o_data;
    logic          o_valid, o_last, o_ready, o_done;
    logic [31:0]   o_checksum;

    int            n_checks = 0, n_fail = 0;
    logic [DW:0]   exp_q[$];
    logic [DW:0]   e, prev_out;
    bit            ones_mode = 1'b0, rnd_ready = 1'b0, prev_stall = 1'b0, pend_v = 1'b0;
    int            iss_idx = 0, n_acc = 0, n_done = 0, n_issue = 0, pend_b = 0, pend_a = 0;
    logic [31:0]   sum_model = '0;

    ifm_bank_reader #(.NUM_BANKS(NB), .DEPTH(D), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .iStart(iStart), .o_enb(o_enb), .o_addrb(o_addrb), .i_dob(i_dob),
        .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_last(o_last), .o_ready(o_ready),
        .o_done(o_done), .o_checksum(o_checksum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW:0] got, input logic [DW:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int b, input int a);
        return ones_mode ? DW'(1) : {32'(b), 32'(a), ~32'(b), ~32'(a)};
    endfunction

    function automatic logic [31:0] lanes(input logic [DW-1:0] w);
        logic [31:0] s = '0;
        for (int i = 0; i < DW / 32; i++) s = s + w[i*32 +: 32];
        return s;
    endfunction

    task automatic push_frame();
        exp_q.delete();
        for (int i = 0; i < NW; i++) exp_q.push_back({i == NW - 1, pat(i / D, i % D)});
        iss_idx   = 0;
        sum_model = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!o_done && n < 20000);
        if (!o_done) check("done_timeout", 1, 0);
    endtask

    task automatic end_frame(input int acc0, input int done0);
        check("words", n_acc - acc0, NW);
        tick();
        check("done_pulse", n_done - done0, 1);
        check("ready_idle", o_ready, 1);
        check("done_low", o_done, 0);
        check("q_empty", exp_q.size(), 0);
`ifdef READER_CHECKSUM_EN
        check("cksum", o_checksum, sum_model);
`else
        check("cksum", o_checksum, 0);
`endif
    endtask

    task automatic check_reset_outs();
        check("rst_valid", o_valid, 0);
        check("rst_last", o_last, 0);
        check("rst_enb", o_enb, 0);
        check("rst_addr", o_addrb, 0);
        check("rst_ready", o_ready, 1);
        check("rst_done", o_done, 0);
        check("rst_cksum", o_checksum, 0);
    endtask

    // Random consumer back-pressure when enabled.
    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_ready) i_ready = ($urandom_range(0, 1) == 1);
    end

    // Bank model (data one cycle after the read), issue-order check and output scoreboard.
    always @(negedge clk) begin
        i_dob  = pend_v ? pat(pend_b, pend_a) : '0;
        pend_v = 1'b0;
        if (!rst) begin
            if (o_enb != '0) begin
                n_issue++;
                check("enb", o_enb, NB'(1) << (iss_idx / D));
                check("addr", o_addrb, AW'(iss_idx % D));
                for (int b = 0; b < NB; b++) if (o_enb[b]) pend_b = b;
                pend_a = int'(o_addrb);
                pend_v = 1'b1;
                iss_idx++;
            end
            if (prev_stall) check("stable", {o_last, o_data}, prev_out);
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) check("extra_word", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("word", {o_last, o_data}, e);
                    sum_model = sum_model + lanes(e[DW-1:0]);
                end
                n_acc++;
            end
            if (o_done) n_done++;
            prev_stall = o_valid && !i_ready;
            prev_out   = {o_last, o_data};
        end else prev_stall = 1'b0;
    end

    initial begin
        int n, acc0, done0, iss0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outs();
        rst = 1'b0;
        tick();
        // Frame 1: full-rate consumer, latency and throughput.
        i_ready = 1'b1;
        acc0 = n_acc; done0 = n_done;
        push_frame();
        iStart = 1'b1;
        tick();
        check("ready_in_run", o_ready, 0);
        check("valid_c0", o_valid, 0);
        tick();
        check("valid_c1", o_valid, 0);
        tick();
        check("valid_c2", o_valid, 1);
        wait_done(n);
        check("frame_cycles", n, NW);
        end_frame(acc0, done0);
        // iStart still high: no second frame.
        acc0 = n_acc; iss0 = n_issue;
        repeat (30) tick();
        check("no_restart_ready", o_ready, 1);
        check("no_restart_words", n_acc - acc0, 0);
        check("no_restart_iss", n_issue - iss0, 0);
        // Frame 2: toggled start, random back-pressure.
        iStart = 1'b0;
        tick();
        acc0 = n_acc; done0 = n_done;
        rnd_ready = 1'b1;
        push_frame();
        iStart = 1'b1;
        wait_done(n);
        rnd_ready = 1'b0;
        i_ready = 1'b1;
        end_frame(acc0, done0);
        // Frame 3: consumer stalled for 20 cycles after start.
        iStart = 1'b0;
        i_ready = 1'b0;
        tick();
        acc0 = n_acc; done0 = n_done; iss0 = n_issue;
        push_frame();
        iStart = 1'b1;
        repeat (20) tick();
        check("stall_issues", (n_issue - iss0) <= 2, 1);
        check("stall_valid", o_valid, 1);
        i_ready = 1'b1;
        wait_done(n);
        end_frame(acc0, done0);
        // Frame 4: reset at word 700 with iStart held high.
        iStart = 1'b0;
        tick();
        acc0 = n_acc;
        push_frame();
        iStart = 1'b1;
        n = 0;
        while (n_acc - acc0 < 700 && n < 5000) begin
            tick();
            n++;
        end
        check("reach_700", n_acc - acc0 >= 700, 1);
        rst = 1'b1;
        tick();
        exp_q.delete();
        check_reset_outs();
        tick();
        rst = 1'b0;
        acc0 = n_acc; done0 = n_done;
        push_frame();
        wait_done(n);
        end_frame(acc0, done0);
        // Frame 5: all-ones lane words for the checksum.
        ones_mode = 1'b1;
        iStart = 1'b0;
        tick();
        acc0 = n_acc; done0 = n_done;
        push_frame();
        iStart = 1'b1;
        wait_done(n);
        end_frame(acc0, done0);
        repeat (5) tick();
`ifdef READER_CHECKSUM_EN
        check("cksum_2048", o_checksum, 2048);
`else
        check("cksum_zero", o_checksum, 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
